// File: rtl/fir3_q26_datapath_pkg.sv
// Shared Q2.6 constants, sample type and load/run state encoding for the 3-tap FIR.
// Arithmetic mode is selected by FIR_SAT_EN (defined: saturate, undefined: wrap).
package fir3_pkg;
    localparam int WI    = 2;
    localparam int WF    = 6;
    localparam int WL    = WI + WF;
    localparam int NTAPS = 3;

    typedef logic signed [WL-1:0] sample_t;

    localparam sample_t SAT_MAX = {1'b0, {(WL-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(WL-1){1'b0}}};

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_t;
endpackage

// File: rtl/fir3_q26_datapath_if.sv
// Sample/coefficient bus of the FIR: source drives enable/x/h, filter returns y/ovf/loaded.
// enable qualifies a run-phase advance only; it is ignored until loaded is high.
interface fir3_q26_datapath_if;
    import fir3_pkg::*;

    logic    enable;
    sample_t x;
    sample_t h;
    sample_t y;
    logic    ovf;
    logic    loaded;

    modport master (output enable, x, h, input y, ovf, loaded);
    modport slave  (input enable, x, h, output y, ovf, loaded);
endinterface

// File: rtl/fir3_q26_datapath_dff.sv
// Plain W-bit register with synchronous active-high reset.
module dff
    import fir3_pkg::*;
#(
    parameter int W = WL
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);
    always_ff @(posedge CLK) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= in;
        end
    end
endmodule

// File: rtl/fir3_q26_datapath_fpadder.sv
// Combinational fixed-point adder with one guard bit; operands and result share the
// same fraction width. Saturates (FIR_SAT_EN defined) or wraps; OVF flags overflow.
module fpadder #(
    parameter int WI1 = 2,
    parameter int WF1 = 6,
    parameter int WI2 = 2,
    parameter int WF2 = 6,
    parameter int WIO = 2,
    parameter int WFO = 6
) (
    input  logic                        RESET,
    input  logic signed [WI1+WF1-1:0]   in1,
    input  logic signed [WI2+WF2-1:0]   in2,
    output logic signed [WIO+WFO-1:0]   out,
    output logic                        OVF
);
    localparam int W1 = WI1 + WF1;
    localparam int W2 = WI2 + WF2;
    localparam int WA = ((W1 > W2) ? W1 : W2) + 1;
    localparam int WO = WIO + WFO;

    logic signed [WA-1:0] w_a;
    logic signed [WA-1:0] w_b;
    logic signed [WA-1:0] w_sum;
    logic                 w_big;

    assign w_a   = WA'(in1);
    assign w_b   = WA'(in2);
    assign w_sum = w_a + w_b;
    assign w_big = !((&w_sum[WA-1:WO-1]) || !(|w_sum[WA-1:WO-1]));

    always_comb begin
        out = '0;
        OVF = 1'b0;
        if (!RESET) begin
            OVF = w_big;
`ifdef FIR_SAT_EN
            if (w_big) begin
                out = w_sum[WA-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
            end else begin
                out = w_sum[WO-1:0];
            end
`else
            out = w_sum[WO-1:0];
`endif
        end
    end
endmodule

// File: rtl/fir3_q26_datapath_fpmult.sv
// Combinational fixed-point multiplier: full product, truncate LSBs toward -inf, then
// saturate (FIR_SAT_EN defined) or wrap (undefined). OVF reports out-of-range either way.
module fpmult #(
    parameter int WI1 = 2,
    parameter int WF1 = 6,
    parameter int WI2 = 2,
    parameter int WF2 = 6,
    parameter int WIO = 2,
    parameter int WFO = 6
) (
    input  logic                        RESET,
    input  logic signed [WI1+WF1-1:0]   in1,
    input  logic signed [WI2+WF2-1:0]   in2,
    output logic signed [WIO+WFO-1:0]   out,
    output logic                        OVF
);
    localparam int WP = WI1 + WF1 + WI2 + WF2;
    localparam int SH = WF1 + WF2 - WFO;
    localparam int WO = WIO + WFO;

    logic signed [WP-1:0] w_prod;
    logic signed [WP-1:0] w_shift;
    logic                 w_big;

    assign w_prod  = WP'(in1) * WP'(in2);
    assign w_shift = w_prod >>> SH;
    // In range only when every bit above the output sign bit matches it.
    assign w_big   = !((&w_shift[WP-1:WO-1]) || !(|w_shift[WP-1:WO-1]));

    always_comb begin
        out = '0;
        OVF = 1'b0;
        if (!RESET) begin
            OVF = w_big;
`ifdef FIR_SAT_EN
            if (w_big) begin
                out = w_shift[WP-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
            end else begin
                out = w_shift[WO-1:0];
            end
`else
            out = w_shift[WO-1:0];
`endif
        end
    end
endmodule

// File: rtl/fir3_q26_datapath.sv
// 3-tap Q2.6 FIR: serial coefficient load from h, then y = c0*x0 + c1*x1 + c2*x2 per enabled edge.
// FIR_SAT_EN selects saturating (defined) or wrapping (undefined) arithmetic.
module fir3_q26_datapath
    import fir3_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fir3_q26_datapath_if.slave   bus
);
    fir_state_t r_state, w_state_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic       w_load, w_adv;

    sample_t r_c0, r_c1, r_c2, r_x0, r_y;
    logic    r_ovf;

    sample_t w_x1, w_x2, w_x1_d, w_x2_d;
    sample_t w_m0, w_m1, w_m2, w_a0, w_a1;
    logic    w_ov_m0, w_ov_m1, w_ov_m2, w_ov_a0, w_ov_a1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The load counter saturates at NTAPS because the last load edge leaves ST_LOAD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load    = 1'b1;
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'(NTAPS - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_adv = bus.enable;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c0  <= '0;
            r_c1  <= '0;
            r_c2  <= '0;
            r_x0  <= '0;
            r_y   <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_load) begin
                r_c0 <= r_c1;
                r_c1 <= r_c2;
                r_c2 <= bus.h;
            end
            if (w_adv) begin
                r_x0  <= bus.x;
                r_y   <= w_a1;
                r_ovf <= r_ovf | w_ov_m0 | w_ov_m1 | w_ov_m2 | w_ov_a0 | w_ov_a1;
            end
        end
    end

    // The delay-line registers have no enable, so stalls recirculate their own value.
    assign w_x1_d = w_adv ? r_x0 : w_x1;
    assign w_x2_d = w_adv ? w_x1 : w_x2;

    dff #(.W(WL)) u_x1 (.CLK(clk), .rst(reset), .in(w_x1_d), .out(w_x1));
    dff #(.W(WL)) u_x2 (.CLK(clk), .rst(reset), .in(w_x2_d), .out(w_x2));

    fpmult #(.WI1(WI), .WF1(WF), .WI2(WI), .WF2(WF), .WIO(WI), .WFO(WF)) u_m0 (
        .RESET(1'b0), .in1(r_c0), .in2(r_x0), .out(w_m0), .OVF(w_ov_m0));
    fpmult #(.WI1(WI), .WF1(WF), .WI2(WI), .WF2(WF), .WIO(WI), .WFO(WF)) u_m1 (
        .RESET(1'b0), .in1(r_c1), .in2(w_x1), .out(w_m1), .OVF(w_ov_m1));
    fpmult #(.WI1(WI), .WF1(WF), .WI2(WI), .WF2(WF), .WIO(WI), .WFO(WF)) u_m2 (
        .RESET(1'b0), .in1(r_c2), .in2(w_x2), .out(w_m2), .OVF(w_ov_m2));

    fpadder #(.WI1(WI), .WF1(WF), .WI2(WI), .WF2(WF), .WIO(WI), .WFO(WF)) u_a0 (
        .RESET(1'b0), .in1(w_m0), .in2(w_m1), .out(w_a0), .OVF(w_ov_a0));
    fpadder #(.WI1(WI), .WF1(WF), .WI2(WI), .WF2(WF), .WIO(WI), .WFO(WF)) u_a1 (
        .RESET(1'b0), .in1(w_a0), .in2(w_m2), .out(w_a1), .OVF(w_ov_a1));

    assign bus.y      = r_y;
    assign bus.ovf    = r_ovf;
    assign bus.loaded = (r_state == ST_RUN);
endmodule

// File: tb/tb_fir3_q26_datapath.sv
// Directed + randomized bench for fir3_q26_datapath against an arithmetic reference model.
// The model follows FIR_SAT_EN the same way the design does.
module tb_fir3_q26_datapath;
    import fir3_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir3_q26_datapath_if bus();

    fir3_q26_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: coefficient list in load order, sample history newest-first.
    int m_coef[$];
    int m_hist[$];
    int m_y;
    bit m_ovf;

    function automatic int sx(logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic bit out_of_range(int v);
        return (v > 127) || (v < -128);
    endfunction

    function automatic int fit(int v);
        int u;
`ifdef FIR_SAT_EN
        u = v;
        if (u > 127) u = 127;
        else if (u < -128) u = -128;
`else
        u = ((v % 256) + 256) % 256;
        if (u >= 128) u -= 256;
`endif
        return u;
    endfunction

    task automatic model_edge(bit rst, bit en, int xv, int hv);
        int p[3];
        int s1;
        int s2;
        bit ov;
        ov = 1'b0;
        if (rst) begin
            m_coef.delete();
            m_hist = '{0, 0, 0};
            m_y    = 0;
            m_ovf  = 1'b0;
        end else if (m_coef.size() < 3) begin
            m_coef.push_back(hv);
        end else if (en) begin
            for (int k = 0; k < 3; k++) begin
                p[k] = (m_coef[k] * m_hist[k]) >>> 6;
                if (out_of_range(p[k])) ov = 1'b1;
                p[k] = fit(p[k]);
            end
            s1 = p[0] + p[1];
            if (out_of_range(s1)) ov = 1'b1;
            s1 = fit(s1);
            s2 = s1 + p[2];
            if (out_of_range(s2)) ov = 1'b1;
            m_y   = fit(s2);
            m_ovf = m_ovf | ov;
            m_hist.push_front(xv);
            void'(m_hist.pop_back());
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step(bit rst, bit en, logic [7:0] xv, logic [7:0] hv);
        @(negedge clk);
        reset      = rst;
        bus.enable = en;
        bus.x      = xv;
        bus.h      = hv;
        @(posedge clk);
        model_edge(rst, en, sx(xv), sx(hv));
        #1;
        chk("y", bus.y, 8'(m_y));
        chk("ovf", {7'd0, bus.ovf}, {7'd0, m_ovf});
        chk("loaded", {7'd0, bus.loaded}, {7'd0, (m_coef.size() == 3)});
    endtask

    task automatic reload(logic [7:0] c0, logic [7:0] c1, logic [7:0] c2);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h55, c0);
        step(1'b0, 1'b1, 8'h55, c1);
        step(1'b0, 1'b1, 8'h55, c2);
    endtask

    task automatic random_run(int n, int en_pct);
        for (int i = 0; i < n; i++) begin
            step(1'b0, ($urandom_range(0, 99) < en_pct), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        bus.x      = '0;
        bus.h      = '0;

        // Reset state and coefficient load 1.0, 0.5, 0.25.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("rst_y", bus.y, 8'h00);
        chk("rst_loaded", {7'd0, bus.loaded}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h40);
        step(1'b0, 1'b0, 8'h00, 8'h20);
        chk("load_2_edges", {7'd0, bus.loaded}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h10);
        chk("load_3_edges", {7'd0, bus.loaded}, 8'h01);

        // Impulse response shows c0, c1, c2 in order after one edge of latency.
        step(1'b0, 1'b1, 8'h40, 8'h00);
        chk("imp_latency", bus.y, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("imp_c0", bus.y, 8'h40);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("imp_c1", bus.y, 8'h20);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("imp_c2", bus.y, 8'h10);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("imp_tail", bus.y, 8'h00);
        chk("imp_ovf", {7'd0, bus.ovf}, 8'h00);

        // Stream, stall 4 cycles with a changing x, then resume.
        random_run(6, 100);
        random_run(4, 0);
        random_run(8, 100);

        // Saturation with all-ones coefficients.
        reload(8'h40, 8'h40, 8'h40);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h7F, 8'h00);
`ifdef FIR_SAT_EN
        chk("sat_pos", bus.y, 8'h7F);
`else
        chk("wrap_pos", bus.y, 8'h7D);
`endif
        chk("sat_ovf", {7'd0, bus.ovf}, 8'h01);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h80, 8'h00);
        chk("sat_neg", bus.y, 8'h80);

        // Multiplier corners through tap 0.
        reload(8'hC0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'hC0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("mul_neg_neg", bus.y, 8'h40);
        chk("mul_neg_neg_ovf", {7'd0, bus.ovf}, 8'h00);
        reload(8'h80, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h80, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h00);
`ifdef FIR_SAT_EN
        chk("mul_min_min", bus.y, 8'h7F);
`else
        chk("mul_min_min", bus.y, 8'h00);
`endif
        chk("mul_min_min_ovf", {7'd0, bus.ovf}, 8'h01);
        reload(8'h01, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h01, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("mul_trunc", bus.y, 8'h00);

        // Random coefficients and stream with random enable.
        reload(8'($urandom), 8'($urandom), 8'($urandom));
        random_run(40, 70);

        // Reset mid-stream, then mid-load, then reload and stream again.
        step(1'b1, 1'b1, 8'h33, 8'h22);
        chk("midrst_y", bus.y, 8'h00);
        chk("midrst_ovf", {7'd0, bus.ovf}, 8'h00);
        chk("midrst_loaded", {7'd0, bus.loaded}, 8'h00);
        random_run(2, 50);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        random_run(3, 50);
        chk("reload_loaded", {7'd0, bus.loaded}, 8'h01);
        random_run(40, 80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fir3_q26_datapath.md
Name: fir3_q26_datapath

Overview:
- 3-tap signed fixed-point FIR filter, y[n] = c0·x[n] + c1·x[n-1] + c2·x[n-2].
- After reset, the three coefficients load serially from port h, then one sample per enabled clock streams through x.
- Built from a register primitive, a fixed-point multiplier and a fixed-point adder.
- Sits in the DSP datapath between the sample source and downstream consumers.

Parameters:
- WI, 2, integer bits including sign, for every operand, product and sum.
- WF, 6, fraction bits. WL = WI+WF = 8 (Q2.6, so 1.0 = 0x40).
- NTAPS, 3, tap count. Fixed at 3; not a generic length.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run-phase advance qualifier.
- x  in  WL  signed sample input.
- h  in  WL  signed coefficient input, valid during the load phase.
- y  out  WL  registered signed filter output.
- ovf  out  1  sticky overflow flag.
- loaded  out  1  high once all coefficients are loaded.

Behaviour:
- Reset (synchronous, at the clk edge with reset=1):
  - clears the load counter, c0..c2, the sample registers x0..x2, y, ovf and loaded.
  - Reset has priority over every other action, including mid-load and mid-stream.
- Load phase (loaded=0), each edge:
  - shift c2<=h, c1<=c2, c0<=c1, and increment the 2-bit counter.
  - After 3 edges: c0 = first h, c1 = second h, c2 = third h; loaded<=1 on the 3rd edge.
  - enable is ignored during load. y, x0..x2 and ovf hold 0.
- Run phase (loaded=1), edges with enable=1:
  - x0<=x, x1<=x0, x2<=x1.
  - y <= sat(sat(c0·x0 + c1·x1) + c2·x2), computed from the pre-edge register values.
  - Coefficients are frozen.
- Run phase, enable=0: all registers hold.
- Latency: a sample captured into x0 at edge n appears in y at edge n+1 (2 edges from presentation on x).
- Multiplier:
  - full 2WL-bit signed product in Q(2WI).(2WF).
  - Drop the WF LSBs by truncation (toward −∞).
  - Saturate to [−2^(WL−1), 2^(WL−1)−1]; its OVF=1 when saturation occurred.
  - Combinational. Its RESET input forces out=0 and OVF=0; tied low here.
- Adder:
  - (WL+1)-bit signed sum, saturated to WL bits; OVF=1 on saturation.
  - Combinational, with the same RESET semantics as the multiplier.
- ovf: set on any enabled run-phase edge where any of the 3 multiplier or 2 adder OVF flags is high. Cleared only by reset.
- Counter stops at 3; no wrap-around.

Optional Feature:
- FIR_SAT_EN defined (default build): saturating arithmetic as described above.
- FIR_SAT_EN undefined:
  - multiplier and adder wrap (two's-complement truncation of the MSBs) instead of saturating.
  - OVF flags are still computed, and ovf still goes sticky, on the same conditions.

Decomposition:
- Package fir3_pkg: WI, WF and WL constants; a signed WL-bit sample typedef; saturation min/max constants.
- Sub-modules:
  - dff: WL-wide register with synchronous reset; ports CLK, rst, in, out.
  - fpmult and fpadder: parameterised by WI1, WF1, WI2, WF2, WIO, WFO; ports RESET, in1, in2, out, OVF.
- Top instantiates 3 fpmult, 2 fpadder and 2 dff for the x1/x2 delay line.

Test Plan:
- Reset then h = 0x40, 0x20, 0x10 -> loaded=1 after 3 edges; c0=0x40, c1=0x20, c2=0x10.
- Impulse: after load, enable=1, x = 0x40 then 0x00 -> y = 0x40, 0x20, 0x10, 0x00 on consecutive edges after the latency; ovf=0.
- Saturation: coefficients all 0x40, x held at 0x7F -> y settles at 0x7F, ovf=1. Repeat with x=0x80 -> y=0x80.
- Multiplier corner cases:
  - c0=0xC0, x=0xC0 -> product 0x40.
  - c0=0x80, x=0x80 -> 0x7F with OVF.
  - c0=0x01, x=0x01 -> 0x00 (truncation).
- Enable stall: drop enable for 4 cycles mid-stream -> y, x0..x2 and ovf hold; resuming continues the sequence without loss.
- Reset mid-stream: assert reset for 1 cycle -> y=0, ovf=0, loaded=0; the next 3 edges reload coefficients from h.
